// File: rtl/cu_sequencer.sv
// Multi-cycle control unit for the J17 datapath: fetches over a req/ack port, decodes,
// and drives one phase of registered datapath controls per state.
module cu_sequencer #(
  parameter int TIMEOUT    = 16,
  parameter int MEM_CYCLES = 2,
  parameter int COUNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        pc,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [4:0]         alucode,
  output logic [2:0]         op1,
  output logic [20:0]        op2,
  output logic               imControl,
  output logic               flag,
  output logic               flag1,
  output logic               regenable,
  output logic [1:0]         ramenable,
  output logic [1:0]         writecode,
  output logic [2:0]         pcControl,
  output logic               pc_step,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [COUNT_W-1:0] retired
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int MEMC_W = (MEM_CYCLES > 1) ? $clog2(MEM_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR} state_t;

  state_t              state, stateNext;
  logic [31:0]         ir, irNext;
  logic [WAIT_W-1:0]   waitCnt, waitCntNext;
  logic [MEMC_W-1:0]   memCnt, memCntNext;
  logic [COUNT_W-1:0]  retiredNext;

  logic [4:0]  opcode;
  logic        isBranch, isMemOp, writesReg, fieldsOn;
  logic [4:0]  branchCode;

  logic        imemReqNext, imControlNext, flagNext, flag1Next, regenableNext, pcStepNext;
  logic        busyNext, haltedNext, errorNext;
  logic [4:0]  alucodeNext;
  logic [2:0]  op1Next, pcControlNext;
  logic [20:0] op2Next;
  logic [1:0]  ramenableNext, writecodeNext;

  assign opcode    = ir[31:27];
  assign isBranch  = (opcode >= 5'd12) && (opcode <= 5'd18);
  assign isMemOp   = (opcode == 5'd20) || (opcode == 5'd21);
  assign writesReg = (opcode <= 5'd11) || (opcode == 5'd19) || (opcode == 5'd20);
  assign imem_addr = imem_req ? pc : 32'd0;

  // Outputs are computed for the state being entered and registered, so every control
  // field changes exactly on the state edge and never depends combinationally on imem_*.
  always_comb begin
    stateNext   = state;
    irNext      = ir;
    waitCntNext = waitCnt;
    memCntNext  = memCnt;
    retiredNext = retired;
    branchCode  = opcode - 5'd11;

    case (state)
      IDLE: begin
        if (start) begin
          stateNext   = FETCH;
          waitCntNext = '0;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          irNext    = imem_rdata;
          stateNext = DECODE;
        end else if (waitCnt == WAIT_W'(TIMEOUT - 1)) begin
          stateNext = ERR;
        end else begin
          waitCntNext = waitCnt + WAIT_W'(1);
        end
      end
      DECODE: begin
        if (opcode == 5'd31) begin
          stateNext   = HALT;
          retiredNext = retired + COUNT_W'(1);
        end else if (opcode > 5'd21) begin
          stateNext = ERR;
        end else begin
          stateNext = EXEC;
        end
      end
      EXEC: begin
        memCntNext = '0;
        stateNext  = isMemOp ? MEM : WB;
      end
      MEM: begin
        if (memCnt == MEMC_W'(MEM_CYCLES - 1)) begin
          stateNext = WB;
        end else begin
          memCntNext = memCnt + MEMC_W'(1);
        end
      end
      WB: begin
        stateNext   = FETCH;
        waitCntNext = '0;
        retiredNext = retired + COUNT_W'(1);
      end
      default: begin
      end
    endcase

    fieldsOn      = (stateNext == EXEC) || (stateNext == MEM) || (stateNext == WB);
    imemReqNext   = (stateNext == FETCH);
    alucodeNext   = (fieldsOn && opcode <= 5'd11) ? opcode : 5'd0;
    op1Next       = fieldsOn ? ir[23:21] : 3'd0;
    op2Next       = fieldsOn ? ir[20:0] : 21'd0;
    imControlNext = fieldsOn && ir[26];
    flagNext      = fieldsOn && (ir[25] || opcode == 5'd20);
    flag1Next     = fieldsOn && ir[24];
    writecodeNext = (fieldsOn && opcode == 5'd19) ? 2'd1 : 2'd0;
    // Only loads and stores ever reach MEM, so the opcode picks read versus write.
    ramenableNext = (stateNext == MEM) ? ((opcode == 5'd20) ? 2'b01 : 2'b10) : 2'b00;
    regenableNext = (stateNext == WB) && writesReg;
    pcStepNext    = (stateNext == WB);
    pcControlNext = ((stateNext == WB) && isBranch) ? branchCode[2:0] : 3'd0;
    busyNext      = (stateNext != IDLE) && (stateNext != HALT) && (stateNext != ERR);
    haltedNext    = (stateNext == HALT);
    errorNext     = (stateNext == ERR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ir        <= '0;
      waitCnt   <= '0;
      memCnt    <= '0;
      retired   <= '0;
      imem_req  <= 1'b0;
      alucode   <= '0;
      op1       <= '0;
      op2       <= '0;
      imControl <= 1'b0;
      flag      <= 1'b0;
      flag1     <= 1'b0;
      regenable <= 1'b0;
      ramenable <= '0;
      writecode <= '0;
      pcControl <= '0;
      pc_step   <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= stateNext;
      ir        <= irNext;
      waitCnt   <= waitCntNext;
      memCnt    <= memCntNext;
      retired   <= retiredNext;
      imem_req  <= imemReqNext;
      alucode   <= alucodeNext;
      op1       <= op1Next;
      op2       <= op2Next;
      imControl <= imControlNext;
      flag      <= flagNext;
      flag1     <= flag1Next;
      regenable <= regenableNext;
      ramenable <= ramenableNext;
      writecode <= writecodeNext;
      pcControl <= pcControlNext;
      pc_step   <= pcStepNext;
      busy      <= busyNext;
      halted    <= haltedNext;
      error     <= errorNext;
    end
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: directed and random instruction streams checked
// cycle by cycle against a phase-level model of the instruction lifecycle.
module tb_cu_sequencer;

  localparam int TIMEOUT    = 16;
  localparam int MEM_CYCLES = 2;
  localparam int COUNT_W    = 2;

  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3;
  localparam int PH_MEM = 4, PH_WB = 5, PH_HALT = 6, PH_ERR = 7;

  logic               clock = 1'b0;
  logic               reset, start, imem_ack;
  logic [31:0]        pc, imem_rdata, imem_addr;
  logic               imem_req, imControl, flag, flag1, regenable, pc_step, busy, halted, error;
  logic [4:0]         alucode;
  logic [2:0]         op1, pcControl;
  logic [20:0]        op2;
  logic [1:0]         ramenable, writecode;
  logic [COUNT_W-1:0] retired;

  int compared   = 0;
  int mismatched = 0;
  int expRet     = 0;

  always #5 clock = ~clock;

  cu_sequencer #(.TIMEOUT(TIMEOUT), .MEM_CYCLES(MEM_CYCLES), .COUNT_W(COUNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alucode(alucode), .op1(op1), .op2(op2), .imControl(imControl), .flag(flag), .flag1(flag1),
    .regenable(regenable), .ramenable(ramenable), .writecode(writecode), .pcControl(pcControl),
    .pc_step(pc_step), .busy(busy), .halted(halted), .error(error), .retired(retired)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] observed();
    return {17'b0, imem_req, alucode, op1, op2, imControl, flag, flag1, regenable,
            ramenable, writecode, pcControl, pc_step, busy, halted, error, retired};
  endfunction

  // What the datapath should see during a given phase of an instruction's life.
  function automatic logic [63:0] expectFor(input int phase, input logic [31:0] ir, input int ret);
    int          op = int'(ir[31:27]);
    logic        on = (phase == PH_EXEC) || (phase == PH_MEM) || (phase == PH_WB);
    logic        wb = (phase == PH_WB);
    logic        req = (phase == PH_FETCH);
    logic [4:0]  alu = (on && op <= 11) ? ir[31:27] : 5'd0;
    logic [2:0]  o1 = on ? ir[23:21] : 3'd0;
    logic [20:0] o2 = on ? ir[20:0] : 21'd0;
    logic        imc = on && ir[26];
    logic        fl = on && (ir[25] || op == 20);
    logic        fl1 = on && ir[24];
    logic        re = wb && (op <= 11 || op == 19 || op == 20);
    logic [1:0]  ram = (phase == PH_MEM) ? ((op == 20) ? 2'b01 : 2'b10) : 2'b00;
    logic [1:0]  wc = (on && op == 19) ? 2'd1 : 2'd0;
    logic [2:0]  pcc = (wb && op >= 12 && op <= 18) ? 3'(op - 11) : 3'd0;
    logic        bz = (phase >= PH_FETCH) && (phase <= PH_WB);
    logic        hl = (phase == PH_HALT);
    logic        er = (phase == PH_ERR);
    logic [COUNT_W-1:0] rt = COUNT_W'(ret % (1 << COUNT_W));
    return {17'b0, req, alu, o1, o2, imc, fl, fl1, re, ram, wc, pcc, wb, bz, hl, er, rt};
  endfunction

  task automatic checkPhase(input string tag, input int phase, input logic [31:0] ir);
    checkOutput(tag, observed(), expectFor(phase, ir, expRet));
    checkOutput({tag, "_addr"}, 64'(imem_addr), (phase == PH_FETCH) ? 64'(pc) : 64'd0);
  endtask

  task automatic applyStimulus(input logic st, input logic ack, input logic [31:0] rd);
    start      = st;
    imem_ack   = ack;
    imem_rdata = rd;
    @(posedge clock);
    #1;
    start    = 1'b0;
    imem_ack = 1'b0;
    pc       = $urandom;
    #1;
  endtask

  task automatic noise();
    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0);
    reset  = 1'b0;
    expRet = 0;
    checkPhase("reset", PH_IDLE, 32'd0);
  endtask

  task automatic doStart();
    checkPhase("idle", PH_IDLE, 32'd0);
    applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom);
  endtask

  // Runs one instruction from its first FETCH cycle; ack arrives after ackDelay idle cycles.
  task automatic runInstr(input logic [31:0] instr, input int ackDelay);
    int op = int'(instr[31:27]);
    for (int k = 0; k <= ackDelay; k++) begin
      checkPhase("fetch", PH_FETCH, 32'd0);
      applyStimulus(1'($urandom_range(0, 1)), k == ackDelay, (k == ackDelay) ? instr : $urandom);
    end
    checkPhase("decode", PH_DECODE, instr);
    noise();
    if (op == 31) begin
      expRet++;
      checkPhase("halt", PH_HALT, instr);
      return;
    end
    if (op > 21) begin
      checkPhase("illegal", PH_ERR, instr);
      return;
    end
    checkPhase("exec", PH_EXEC, instr);
    if (op == 20 || op == 21) begin
      for (int m = 0; m < MEM_CYCLES; m++) begin
        noise();
        checkPhase("mem", PH_MEM, instr);
      end
    end
    noise();
    checkPhase("wb", PH_WB, instr);
    noise();
    expRet++;
    checkPhase("fetch_next", PH_FETCH, 32'd0);
  endtask

  function automatic logic [31:0] makeInstr(input int op);
    logic [31:0] r = $urandom;
    return {5'(op), r[26:0]};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; pc = 32'd0;
    applyStimulus(1'b0, 1'b0, 32'd0);
    doReset();
    applyStimulus(1'b0, 1'b1, $urandom);
    checkPhase("idle_hold", PH_IDLE, 32'd0);

    doStart();
    runInstr(32'h08200005, 0);
    runInstr(32'hA3000000, 2);
    runInstr(32'hA8000000, 1);
    runInstr(32'h60000000, 0);
    runInstr(makeInstr(19), TIMEOUT - 1);
    for (int i = 0; i < 40; i++)
      runInstr(makeInstr($urandom_range(0, 21)), $urandom_range(0, 3));
    runInstr(makeInstr($urandom_range(22, 30)), 0);
    for (int i = 0; i < 4; i++) begin
      noise();
      checkPhase("err_hold", PH_ERR, 32'd0);
    end

    doReset();
    doStart();
    for (int k = 0; k < TIMEOUT; k++) begin
      checkPhase("fetch_wait", PH_FETCH, 32'd0);
      applyStimulus(1'($urandom_range(0, 1)), 1'b0, $urandom);
    end
    checkPhase("timeout", PH_ERR, 32'd0);
    applyStimulus(1'b0, 1'b1, $urandom);
    checkPhase("timeout_hold", PH_ERR, 32'd0);

    doReset();
    doStart();
    runInstr(makeInstr($urandom_range(0, 11)), 0);
    runInstr(32'hF8000000, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom);
      checkPhase("halt_hold", PH_HALT, 32'd0);
    end

    doReset();
    doStart();
    runInstr(32'h08200005, 1);
    checkPhase("abort_fetch", PH_FETCH, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'hA3000000);
    checkPhase("abort_decode", PH_DECODE, 32'hA3000000);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkPhase("abort_exec", PH_EXEC, 32'hA3000000);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkPhase("abort_mem", PH_MEM, 32'hA3000000);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0);
    reset  = 1'b0;
    expRet = 0;
    checkPhase("abort_reset", PH_IDLE, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkPhase("abort_after", PH_IDLE, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
